// File: rtl/fan_speed_ctrl_pkg.sv
// rtl/fan_speed_ctrl_pkg.sv - shared state encoding and default widths for the fan speed controller
package fan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        RUN  = 2'd2
    } fan_state_t;

    localparam int FAN_DUTY_W   = 10;
    localparam int FAN_RPM_W    = 16;
    localparam int FAN_MIN_DUTY = 128;

endpackage

// File: rtl/fan_speed_ctrl_if.sv
// rtl/fan_speed_ctrl_if.sv - target write handshake and tach measurement strobe
interface fan_speed_ctrl_if #(
    parameter int RPM_W = fan_pkg::FAN_RPM_W
) ();
    logic             target_valid;
    logic             target_ready;
    logic [RPM_W-1:0] target_rpm;
    logic             rpm_valid;
    logic [RPM_W-1:0] rpm;

    modport master (
        output target_valid, target_rpm, rpm_valid, rpm,
        input  target_ready
    );

    modport slave (
        input  target_valid, target_rpm, rpm_valid, rpm,
        output target_ready
    );
endinterface

// File: rtl/fan_speed_ctrl_duty_step.sv
// rtl/fan_speed_ctrl_duty_step.sv - one proportional duty step: scaled tach error added to duty, clamped
module fan_duty_step #(
    parameter int DUTY_W     = fan_pkg::FAN_DUTY_W,
    parameter int RPM_W      = fan_pkg::FAN_RPM_W,
    parameter int MIN_DUTY   = fan_pkg::FAN_MIN_DUTY,
    parameter int STEP_SHIFT = 2
) (
    input  logic [DUTY_W-1:0] duty,
    input  logic [RPM_W-1:0]  tgt,
    input  logic [RPM_W-1:0]  rpm,
    output logic [DUTY_W-1:0] duty_next
);
    localparam int ERR_W = RPM_W + 1;
    localparam int SUM_W = RPM_W + 2;
    localparam logic signed [SUM_W-1:0] SUM_LO = SUM_W'(MIN_DUTY);
    localparam logic signed [SUM_W-1:0] SUM_HI = SUM_W'((1 << DUTY_W) - 1);

    logic signed [ERR_W-1:0] err;
    logic signed [ERR_W-1:0] delta;
    logic signed [SUM_W-1:0] sum;

    always_comb begin
        err   = $signed({1'b0, tgt}) - $signed({1'b0, rpm});
        delta = err >>> STEP_SHIFT;
        sum   = $signed({{(SUM_W-DUTY_W){1'b0}}, duty})
              + $signed({{(SUM_W-ERR_W){delta[ERR_W-1]}}, delta});
        if (sum < SUM_LO) begin
            duty_next = DUTY_W'(MIN_DUTY);
        end else if (sum > SUM_HI) begin
            duty_next = '1;
        end else begin
            duty_next = sum[DUTY_W-1:0];
        end
    end
endmodule

// File: rtl/fan_speed_ctrl.sv
// rtl/fan_speed_ctrl.sv - closed-loop fan duty controller with kick-start; FAN_STALL_DETECT_EN adds stall recovery
module fan_speed_ctrl
    import fan_pkg::*;
#(
    parameter int DUTY_W        = FAN_DUTY_W,
    parameter int RPM_W         = FAN_RPM_W,
    parameter int MIN_DUTY      = FAN_MIN_DUTY,
    parameter int STEP_SHIFT    = 2,
    parameter int KICK_WINDOWS  = 2,
    parameter int STALL_WINDOWS = 3
) (
    input  logic              host_clk,
    input  logic              reset,
    fan_speed_ctrl_if.slave   bus,
    output logic [DUTY_W-1:0] duty,
    output logic              stalled,
    output logic [1:0]        state
);
    localparam int KC_W = $clog2(KICK_WINDOWS) + 1;

    fan_state_t        state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [RPM_W-1:0]  tgt_q, tgt_d;
    logic [KC_W-1:0]   kick_cnt_q, kick_cnt_d;
    logic [DUTY_W-1:0] step_duty;
    logic              wr_acc;
`ifdef FAN_STALL_DETECT_EN
    localparam int ZC_W = $clog2(STALL_WINDOWS + 1);
    logic [ZC_W-1:0]   zero_cnt_q, zero_cnt_d;
    logic              stalled_q, stalled_d;
`endif

    // Measurements win over writes; the writer simply retries next cycle.
    assign bus.target_ready = !bus.rpm_valid;
    assign wr_acc           = bus.target_valid && bus.target_ready;

    fan_duty_step #(
        .DUTY_W     (DUTY_W),
        .RPM_W      (RPM_W),
        .MIN_DUTY   (MIN_DUTY),
        .STEP_SHIFT (STEP_SHIFT)
    ) u_step (
        .duty      (duty_q),
        .tgt       (tgt_q),
        .rpm       (bus.rpm),
        .duty_next (step_duty)
    );

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        tgt_d      = tgt_q;
        kick_cnt_d = kick_cnt_q;
`ifdef FAN_STALL_DETECT_EN
        zero_cnt_d = zero_cnt_q;
        stalled_d  = stalled_q;
`endif
        if (wr_acc) begin
            tgt_d = bus.target_rpm;
`ifdef FAN_STALL_DETECT_EN
            stalled_d = 1'b0;
`endif
            if (bus.target_rpm == '0) begin
                state_d    = IDLE;
                duty_d     = '0;
                kick_cnt_d = '0;
`ifdef FAN_STALL_DETECT_EN
                zero_cnt_d = '0;
`endif
            end else if (state_q == IDLE) begin
                state_d    = KICK;
                duty_d     = '1;
                kick_cnt_d = '0;
            end
        end else if (bus.rpm_valid) begin
            case (state_q)
                KICK: begin
                    kick_cnt_d = kick_cnt_q + 1'b1;
                    if (kick_cnt_q == KC_W'(KICK_WINDOWS - 1)) begin
                        state_d = RUN;
                        duty_d  = DUTY_W'(MIN_DUTY);
                    end
                end
                RUN: begin
                    duty_d = step_duty;
`ifdef FAN_STALL_DETECT_EN
                    if (bus.rpm != '0) begin
                        zero_cnt_d = '0;
                    end else if (zero_cnt_q != ZC_W'(STALL_WINDOWS)) begin
                        zero_cnt_d = zero_cnt_q + 1'b1;
                    end
                    // A stall re-kicks the fan at full duty rather than stepping.
                    if (zero_cnt_d == ZC_W'(STALL_WINDOWS)) begin
                        stalled_d  = 1'b1;
                        duty_d     = '1;
                        kick_cnt_d = '0;
                        zero_cnt_d = '0;
                        state_d    = KICK;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge host_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            duty_q     <= '0;
            tgt_q      <= '0;
            kick_cnt_q <= '0;
`ifdef FAN_STALL_DETECT_EN
            zero_cnt_q <= '0;
            stalled_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            tgt_q      <= tgt_d;
            kick_cnt_q <= kick_cnt_d;
`ifdef FAN_STALL_DETECT_EN
            zero_cnt_q <= zero_cnt_d;
            stalled_q  <= stalled_d;
`endif
        end
    end

    assign duty  = duty_q;
    assign state = state_q;
`ifdef FAN_STALL_DETECT_EN
    assign stalled = stalled_q;
`else
    assign stalled = 1'b0;
`endif
endmodule
